sdram_port_arb: RTL and testbench

Three-port arbiter and sequencer for the shared byte-wide SDRAM controller.
- It merges ROM-pack/tape download writes (a strobe stream from the HPS loader), cassette playback reads and cartridge ROM reads into one command stream.
- It issues one SDRAM command at a time and returns read data to the requester that owns it.
- It sits between the loader/cassette/cartridge logic and the `sdram` instance, replacing the direct download-versus-cassette address mux.

---
 rtl/sdram_port_arb.sv | 175 +++++++++++++++++
 tb/tb_sdram_port_arb.sv | 549 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: one-at-a-time SDRAM sequencer that merges a buffered download
// write port with tape (and optionally cartridge) read ports.
// Optional feature macro: SDRAM_ARB_CART_EN (cartridge read port, round-robin with tape).
// Ports: clk; reset (async, active-low);
//   wr_strobe/wr_addr/wr_data in, wr_full/wr_ovf out (1-entry write buffer);
//   t_req/t_addr in, t_ack/t_data out (tape read); c_* same for cartridge;
//   sdram_addr/sdram_din/sdram_rd/sdram_we out, sdram_done/sdram_dout in;
//   busy (state not IDLE), tmo_err (sticky command timeout).
module sdram_port_arb #(
    parameter int AW  = 25,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_strobe,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_full,
    output logic          wr_ovf,
    input  logic          t_req,
    input  logic [AW-1:0] t_addr,
    output logic          t_ack,
    output logic [7:0]    t_data,
    input  logic          c_req,
    input  logic [AW-1:0] c_addr,
    output logic          c_ack,
    output logic [7:0]    c_data,
    output logic [AW-1:0] sdram_addr,
    output logic [7:0]    sdram_din,
    output logic          sdram_rd,
    output logic          sdram_we,
    input  logic          sdram_done,
    input  logic [7:0]    sdram_dout,
    output logic          busy,
    output logic          tmo_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_WR, OWN_T, OWN_C} own_t;

    localparam logic [7:0] TMO_CNT = 8'(TMO);

    state_t        state;
    own_t          own;
    logic [7:0]    cnt;
    logic [AW-1:0] wb_addr;
    logic [7:0]    wb_data;
    logic          wb_pend;   // buffer holds a write not yet granted
    logic          wr_issue;
    logic          wr_take;
    logic          pick_t;
    logic          pick_c;
    logic [AW-1:0] rd_addr;

    // The buffer contents are copied into sdram_addr/din at grant, so a
    // strobe during the write's ISSUE cycle can safely refill it.
    assign wr_issue = (state == S_ISSUE) && (own == OWN_WR);
    assign wr_take  = wr_strobe && (!wr_full || wr_issue);
    assign busy     = (state != S_IDLE);

`ifdef SDRAM_ARB_CART_EN
    logic last;   // 1: cartridge had the most recent read grant
    assign pick_t  = t_req && (!c_req || last);
    assign pick_c  = c_req && !pick_t;
    assign rd_addr = pick_t ? t_addr : c_addr;
`else
    logic unused_c;
    assign unused_c = c_req ^ (^c_addr);
    assign pick_t   = t_req;
    assign pick_c   = 1'b0;
    assign rd_addr  = t_addr;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            own        <= OWN_WR;
            cnt        <= '0;
            wb_addr    <= '0;
            wb_data    <= '0;
            wb_pend    <= 1'b0;
            wr_full    <= 1'b0;
            wr_ovf     <= 1'b0;
            t_ack      <= 1'b0;
            t_data     <= '0;
            c_ack      <= 1'b0;
            c_data     <= '0;
            sdram_addr <= '0;
            sdram_din  <= '0;
            sdram_rd   <= 1'b0;
            sdram_we   <= 1'b0;
            tmo_err    <= 1'b0;
`ifdef SDRAM_ARB_CART_EN
            last       <= 1'b1;
`endif
        end else begin
            sdram_rd <= 1'b0;
            sdram_we <= 1'b0;
            t_ack    <= 1'b0;
            c_ack    <= 1'b0;

            if (wr_take) begin
                wb_addr <= wr_addr;
                wb_data <= wr_data;
                wb_pend <= 1'b1;
                wr_full <= 1'b1;
            end else if (wr_strobe) begin
                wr_ovf <= 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (wb_pend) begin
                        own        <= OWN_WR;
                        sdram_addr <= wb_addr;
                        sdram_din  <= wb_data;
                        sdram_we   <= 1'b1;
                        wb_pend    <= 1'b0;
                        state      <= S_ISSUE;
                    // A strobe arriving now becomes a pending write next
                    // cycle and must win, so hold off read grants.
                    end else if (!wr_strobe && (pick_t || pick_c)) begin
                        own        <= pick_t ? OWN_T : OWN_C;
                        sdram_addr <= rd_addr;
                        sdram_rd   <= 1'b1;
                        state      <= S_ISSUE;
`ifdef SDRAM_ARB_CART_EN
                        last       <= pick_c;
`endif
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (sdram_done) begin
                        if (own == OWN_WR) begin
                            wr_full <= wb_pend;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_RESP;
                            if (own == OWN_T) begin
                                t_ack  <= 1'b1;
                                t_data <= sdram_dout;
                            end else begin
                                c_ack  <= 1'b1;
                                c_data <= sdram_dout;
                            end
                        end
                    end else if (cnt == TMO_CNT) begin
                        tmo_err <= 1'b1;
                        state   <= S_RESP;
                        if (own == OWN_WR) begin
                            wr_full <= wb_pend;
                        end else if (own == OWN_T) begin
                            t_ack  <= 1'b1;
                            t_data <= 8'hFF;
                        end else begin
                            c_ack  <= 1'b1;
                            c_data <= 8'hFF;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: randomized scenario bench for sdram_port_arb with an
// SDRAM responder model and a byte-level expected-memory model.
module tb_sdram_port_arb;

    localparam int AW = 25;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_strobe = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_full, wr_ovf;
    logic          t_req = 1'b0;
    logic [AW-1:0] t_addr = '0;
    logic          t_ack;
    logic [7:0]    t_data;
    logic          c_req = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic          c_ack;
    logic [7:0]    c_data;
    logic [AW-1:0] sdram_addr;
    logic [7:0]    sdram_din;
    logic          sdram_rd, sdram_we;
    logic          sdram_done;
    logic [7:0]    sdram_dout;
    logic          busy, tmo_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lat = 3;
    bit stall = 1'b0;

    logic [7:0] mem [logic [AW-1:0]];
    logic [7:0] exp_mem [logic [AW-1:0]];

    sdram_port_arb #(.AW(AW), .TMO(TMO)) dut (
        .clk(clk), .reset(rst_n),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_full(wr_full), .wr_ovf(wr_ovf),
        .t_req(t_req), .t_addr(t_addr), .t_ack(t_ack), .t_data(t_data),
        .c_req(c_req), .c_addr(c_addr), .c_ack(c_ack), .c_data(c_data),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din),
        .sdram_rd(sdram_rd), .sdram_we(sdram_we),
        .sdram_done(sdram_done), .sdram_dout(sdram_dout),
        .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mdef(logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ {7'd0, a[24]} ^ 8'h96;
    endfunction

    function automatic logic [7:0] exp_rd(logic [AW-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : mdef(a);
    endfunction

    // SDRAM responder: done pulse lat cycles after a command, unless stalled.
    initial begin : responder
        int dn;
        logic [7:0] rb;
        dn = 0;
        rb = '0;
        sdram_done = 1'b0;
        sdram_dout = '0;
        forever begin
            @(negedge clk);
            sdram_done = 1'b0;
            if (dn > 0) begin
                dn--;
                if (dn == 0) begin
                    sdram_done = 1'b1;
                    sdram_dout = rb;
                end
            end
            if (!stall && (sdram_rd || sdram_we)) begin
                dn = lat;
                if (sdram_we) mem[sdram_addr] = sdram_din;
                rb = mem.exists(sdram_addr) ? mem[sdram_addr] : mdef(sdram_addr);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || wr_full) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy || wr_full) begin
            tests++;
            fails++;
            $display("FAIL idle_wait busy=%0b wr_full=%0b want 0 0", busy, wr_full);
        end
    endtask

    task automatic tape_read(input logic [AW-1:0] a, output int n, output int cc,
                             output int ac, output logic [7:0] d);
        n = cyc;
        cc = -1;
        ac = -1;
        d = '0;
        t_addr = a;
        t_req = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sdram_rd && cc < 0) cc = cyc;
            if (t_ack) begin
                ac = cyc;
                d = t_data;
                break;
            end
        end
        t_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({wr_full, wr_ovf, t_ack, c_ack, sdram_rd, sdram_we, busy, tmo_err} !== 8'h00) begin
            fails++;
            $display("FAIL reset_flags got %b want 00000000",
                     {wr_full, wr_ovf, t_ack, c_ack, sdram_rd, sdram_we, busy, tmo_err});
        end
        tests++;
        if (sdram_addr !== '0 || sdram_din !== 8'h00) begin
            fails++;
            $display("FAIL reset_cmd addr=%h din=%h want 0 0", sdram_addr, sdram_din);
        end
        tests++;
        if (t_data !== 8'h00 || c_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data t=%h c=%h want 0 0", t_data, c_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle busy=%0b want 0", busy);
        end
    endtask

    task automatic test_tape_read();
        int n, cc, ac, wc;
        logic [7:0] d;
        wait_idle();
        lat = 2;
        n = cyc;
        wc = -1;
        wr_addr = 25'h000100;
        wr_data = 8'h5A;
        wr_strobe = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            wr_strobe = 1'b0;
            if (sdram_we) begin
                wc = cyc;
                break;
            end
        end
        tests++;
        if (wc !== n + 2 || sdram_din !== 8'h5A) begin
            fails++;
            $display("FAIL write_timing we_cyc=%0d din=%h want %0d 5a", wc, sdram_din, n + 2);
        end
        exp_mem[25'h000100] = 8'h5A;
        wait_idle();
        lat = 5;
        tape_read(25'h000100, n, cc, ac, d);
        tests++;
        if (cc !== n + 1) begin
            fails++;
            $display("FAIL tape_cmd cyc=%0d want %0d", cc, n + 1);
        end
        tests++;
        if (ac !== n + 7 || d !== 8'h5A) begin
            fails++;
            $display("FAIL tape_ack cyc=%0d data=%h want %0d 5a", ac, d, n + 7);
        end
        @(negedge clk);
        tests++;
        if (t_data !== 8'h5A || sdram_addr !== 25'h000100 || t_ack !== 1'b0) begin
            fails++;
            $display("FAIL tape_hold data=%h addr=%h ack=%0b want 5a 100 0", t_data, sdram_addr, t_ack);
        end
    endtask

    task automatic test_random_reads();
        int n, cc, ac;
        logic [7:0] d;
        logic [AW-1:0] a;
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            a = AW'($urandom);
            if (i == 0) a = 25'h000100;
            lat = $urandom_range(1, 6);
            tape_read(a, n, cc, ac, d);
            tests++;
            if (cc !== n + 1 || ac !== n + 2 + lat) begin
                fails++;
                $display("FAIL rand_timing cmd=%0d ack=%0d want %0d %0d", cc, ac, n + 1, n + 2 + lat);
            end
            tests++;
            if (d !== exp_rd(a)) begin
                fails++;
                $display("FAIL rand_data addr=%h got %h want %h", a, d, exp_rd(a));
            end
        end
    endtask

    task automatic test_write_priority();
        int n, wc, rc, ac;
        logic [AW-1:0] wa;
        logic [7:0] wd, d;
        wait_idle();
        lat = $urandom_range(1, 5);
        n = cyc;
        wc = -1;
        rc = -1;
        ac = -1;
        wa = '0;
        wd = '0;
        d = '0;
        wr_addr = 25'h000010;
        wr_data = 8'hA5;
        wr_strobe = 1'b1;
        t_addr = 25'h000010;
        t_req = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            wr_strobe = 1'b0;
            if (sdram_we && wc < 0) begin
                wc = cyc;
                wa = sdram_addr;
                wd = sdram_din;
            end
            if (sdram_rd && rc < 0) rc = cyc;
            if (t_ack) begin
                ac = cyc;
                d = t_data;
                break;
            end
        end
        t_req = 1'b0;
        exp_mem[25'h000010] = 8'hA5;
        tests++;
        if (wc !== n + 2 || wa !== 25'h000010 || wd !== 8'hA5) begin
            fails++;
            $display("FAIL prio_write cyc=%0d addr=%h din=%h want %0d 10 a5", wc, wa, wd, n + 2);
        end
        tests++;
        if (rc !== n + 4 + lat) begin
            fails++;
            $display("FAIL prio_read_cmd cyc=%0d want %0d", rc, n + 4 + lat);
        end
        tests++;
        if (ac !== n + 5 + 2 * lat || d !== 8'hA5) begin
            fails++;
            $display("FAIL prio_read_ack cyc=%0d data=%h want %0d a5", ac, d, n + 5 + 2 * lat);
        end
    endtask

    task automatic test_timeout();
        int n, cc, ac;
        logic [7:0] d;
        wait_idle();
        tests++;
        if (tmo_err !== 1'b0) begin
            fails++;
            $display("FAIL tmo_pre got %0b want 0", tmo_err);
        end
        stall = 1'b1;
        tape_read(AW'($urandom), n, cc, ac, d);
        stall = 1'b0;
        tests++;
        if (cc !== n + 1 || ac !== cc + TMO + 2) begin
            fails++;
            $display("FAIL tmo_timing cmd=%0d ack=%0d want %0d %0d", cc, ac, n + 1, n + TMO + 3);
        end
        tests++;
        if (d !== 8'hFF || tmo_err !== 1'b1) begin
            fails++;
            $display("FAIL tmo_result data=%h err=%0b want ff 1", d, tmo_err);
        end
    endtask

    task automatic test_wr_buffer();
        int n, wc;
        logic [AW-1:0] a1, a2, a3, wa;
        logic [7:0] d1, d2, d3, wd;
        wait_idle();
        a1 = AW'($urandom);
        a2 = a1 ^ 25'h0000F0;
        a3 = a1 ^ 25'h000F00;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        d3 = ~d2;
        lat = 3;
        stall = 1'b1;
        n = cyc;
        wr_addr = a1;
        wr_data = d1;
        wr_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
        @(negedge clk);
        tests++;
        if (sdram_we !== 1'b1 || sdram_addr !== a1 || sdram_din !== d1) begin
            fails++;
            $display("FAIL buf_issue we=%0b addr=%h din=%h want 1 %h %h", sdram_we, sdram_addr, sdram_din, a1, d1);
        end
        wr_addr = a2;
        wr_data = d2;
        wr_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
        tests++;
        if (wr_full !== 1'b1 || wr_ovf !== 1'b0) begin
            fails++;
            $display("FAIL buf_issue_strobe full=%0b ovf=%0b want 1 0", wr_full, wr_ovf);
        end
        wr_addr = a3;
        wr_data = d3;
        wr_strobe = 1'b1;
        @(negedge clk);
        wr_strobe = 1'b0;
        tests++;
        if (wr_ovf !== 1'b1) begin
            fails++;
            $display("FAIL buf_ovf got %0b want 1", wr_ovf);
        end
        stall = 1'b0;
        wc = -1;
        wa = '0;
        wd = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sdram_we) begin
                wc = cyc;
                wa = sdram_addr;
                wd = sdram_din;
                break;
            end
        end
        tests++;
        if (wc !== n + TMO + 6 || wa !== a2 || wd !== d2) begin
            fails++;
            $display("FAIL buf_second cyc=%0d addr=%h din=%h want %0d %h %h", wc, wa, wd, n + TMO + 6, a2, d2);
        end
        tests++;
        if (tmo_err !== 1'b1) begin
            fails++;
            $display("FAIL buf_tmo got %0b want 1", tmo_err);
        end
        exp_mem[a2] = d2;
        wait_idle();
        tests++;
        if (wr_full !== 1'b0 || wr_ovf !== 1'b1) begin
            fails++;
            $display("FAIL buf_drain full=%0b ovf=%0b want 0 1", wr_full, wr_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int n, cc, ac;
        bit bad;
        logic [7:0] d;
        logic [AW-1:0] a;
        wait_idle();
        lat = 4;
        a = AW'($urandom);
        cc = -1;
        t_addr = a;
        t_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sdram_rd) begin
                cc = cyc;
                break;
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        t_req = 1'b0;
        #1;
        tests++;
        if ({wr_full, wr_ovf, t_ack, c_ack, sdram_rd, sdram_we, busy, tmo_err} !== 8'h00 ||
            sdram_addr !== '0 || t_data !== 8'h00) begin
            fails++;
            $display("FAIL rst_mid_out flags=%b addr=%h tdata=%h want 0 0 0",
                     {wr_full, wr_ovf, t_ack, c_ack, sdram_rd, sdram_we, busy, tmo_err}, sdram_addr, t_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (t_ack || busy || sdram_rd) bad = 1'b1;
        end
        tests++;
        if (bad || cc < 0) begin
            fails++;
            $display("FAIL rst_late_done bad=%0b cmd=%0d want 0 and cmd seen", bad, cc);
        end
        tape_read(a, n, cc, ac, d);
        tests++;
        if (cc !== n + 1 || ac !== n + 6 || d !== exp_rd(a)) begin
            fails++;
            $display("FAIL rst_after cmd=%0d ack=%0d data=%h want %0d %0d %h", cc, ac, d, n + 1, n + 6, exp_rd(a));
        end
    endtask

`ifdef SDRAM_ARB_CART_EN
    task automatic test_back_to_back();
        int order[$];
        int rds[$];
        logic [AW-1:0] ta, ca;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lat = $urandom_range(1, 5);
        ta = AW'($urandom);
        ca = ta ^ 25'h001000;
        t_addr = ta;
        c_addr = ca;
        t_req = 1'b1;
        c_req = 1'b1;
        for (int k = 0; k < 200 && order.size() < 4; k++) begin
            @(negedge clk);
            if (sdram_rd) rds.push_back(cyc);
            if (t_ack) begin
                order.push_back(0);
                tests++;
                if (t_data !== exp_rd(ta)) begin
                    fails++;
                    $display("FAIL b2b_tdata got %h want %h", t_data, exp_rd(ta));
                end
            end
            if (c_ack) begin
                order.push_back(1);
                tests++;
                if (c_data !== exp_rd(ca)) begin
                    fails++;
                    $display("FAIL b2b_cdata got %h want %h", c_data, exp_rd(ca));
                end
            end
        end
        t_req = 1'b0;
        c_req = 1'b0;
        tests++;
        if (order.size() != 4 || rds.size() < 4) begin
            fails++;
            $display("FAIL b2b_count acks=%0d cmds=%0d want 4 4", order.size(), rds.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (order[i] != i % 2) begin
                    fails++;
                    $display("FAIL b2b_order idx=%0d got %0d want %0d", i, order[i], i % 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (rds[i+1] - rds[i] != 3 + lat) begin
                    fails++;
                    $display("FAIL b2b_spacing idx=%0d got %0d want %0d", i, rds[i+1] - rds[i], 3 + lat);
                end
            end
        end
    endtask
`else
    task automatic test_back_to_back();
        int rds[$];
        int nack;
        bit cbad;
        logic [AW-1:0] ta;
        wait_idle();
        lat = $urandom_range(1, 5);
        ta = AW'($urandom);
        nack = 0;
        cbad = 1'b0;
        t_addr = ta;
        c_addr = ta ^ 25'h001000;
        t_req = 1'b1;
        c_req = 1'b1;
        for (int k = 0; k < 200 && nack < 4; k++) begin
            @(negedge clk);
            if (sdram_rd) rds.push_back(cyc);
            if (c_ack || c_data !== 8'h00) cbad = 1'b1;
            if (t_ack) begin
                nack++;
                tests++;
                if (t_data !== exp_rd(ta)) begin
                    fails++;
                    $display("FAIL b2b_tdata got %h want %h", t_data, exp_rd(ta));
                end
            end
        end
        t_req = 1'b0;
        c_req = 1'b0;
        tests++;
        if (cbad || nack != 4) begin
            fails++;
            $display("FAIL b2b_cart_off cart_activity=%0b tape_acks=%0d want 0 4", cbad, nack);
        end
        for (int i = 0; i + 1 < rds.size(); i++) begin
            tests++;
            if (rds[i+1] - rds[i] != 3 + lat) begin
                fails++;
                $display("FAIL b2b_spacing idx=%0d got %0d want %0d", i, rds[i+1] - rds[i], 3 + lat);
            end
        end
        repeat (20) @(negedge clk);
        tests++;
        if (c_ack !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_quiet c_ack=%0b busy=%0b want 0 0", c_ack, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tape_read();
        test_random_reads();
        test_write_priority();
        test_timeout();
        test_wr_buffer();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
